// File: rtl/aplic_msi_tx.sv
// rtl/aplic_msi_tx.sv - APLIC MSI transmitter: request FIFO feeding single-beat AXI writes to IMSIC seteipnum
module aplic_msi_tx #(
    parameter int          NR_IMSICS             = 4,
    parameter int          NR_VS_FILES_PER_IMSIC = 1,
    parameter int          NR_SRC_IMSIC          = 64,
    parameter int          FIFO_DEPTH            = 4,
    parameter logic [63:0] M_BASE                = 64'h2400_0000,
    parameter logic [63:0] S_BASE                = 64'h2800_0000,
    parameter logic [3:0]  AXI_ID                = 4'h0,
    localparam int HART_W  = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1,
    localparam int GUEST_W = (NR_VS_FILES_PER_IMSIC > 0) ? $clog2(NR_VS_FILES_PER_IMSIC + 1) : 1,
    localparam int EIID_W  = $clog2(NR_SRC_IMSIC)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_level,
    input  logic [HART_W-1:0]  i_req_hart,
    input  logic [GUEST_W-1:0] i_req_guest,
    input  logic [EIID_W-1:0]  i_req_eiid,
    output logic               o_awvalid,
    input  logic               i_awready,
    output logic [63:0]        o_awaddr,
    output logic [3:0]         o_awid,
    output logic [7:0]         o_awlen,
    output logic [2:0]         o_awsize,
    output logic [1:0]         o_awburst,
    output logic               o_wvalid,
    input  logic               i_wready,
    output logic [63:0]        o_wdata,
    output logic [7:0]         o_wstrb,
    output logic               o_wlast,
    input  logic               i_bvalid,
    output logic               o_bready,
    input  logic [1:0]         i_bresp,
    output logic               o_drop,
    output logic               o_bus_err,
    output logic               o_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [63:0] FILE_STRIDE   = 64'h1000;
    localparam logic [63:0] S_HART_STRIDE = 64'((1 + NR_VS_FILES_PER_IMSIC) * 4096);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_B
    } state_t;

    state_t state, state_d;

    // Request queue storage: the target address is resolved at enqueue time
    logic [63:0]       addr_mem [FIFO_DEPTH];
    logic [EIID_W-1:0] eiid_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic        full, empty, accept, legal, push, pop;
    logic [63:0] req_addr;

    logic        aw_done, w_done, aw_done_d, w_done_d;
    logic        load;
    logic        bus_err_d;
    logic [63:0] awaddr_q, wdata_q;
    logic [7:0]  wstrb_q;
    logic        drop_q, bus_err_q;

    logic [63:0]       head_addr;
    logic [EIID_W-1:0] head_eiid;

    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign o_req_ready = !full;
    assign accept      = i_req_valid && !full;
    assign push        = accept && legal;
    assign pop         = load;

    assign head_addr = addr_mem[rd_ptr];
    assign head_eiid = eiid_mem[rd_ptr];

    // Legality check and target-file address for the incoming request
    always_comb begin
        legal = (i_req_eiid != '0)
             && (32'(i_req_eiid) < 32'(NR_SRC_IMSIC))
             && (32'(i_req_hart) < 32'(NR_IMSICS))
             && (!i_req_level || (32'(i_req_guest) <= 32'(NR_VS_FILES_PER_IMSIC)));
        if (i_req_level) begin
            req_addr = S_BASE + 64'(i_req_hart) * S_HART_STRIDE + 64'(i_req_guest) * FILE_STRIDE;
        end else begin
            req_addr = M_BASE + 64'(i_req_hart) * FILE_STRIDE;
        end
    end

    // Queue payload write; contents need no reset since count gates every read
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= req_addr;
            eiid_mem[wr_ptr] <= i_req_eiid;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Next-state logic: IDLE pops, SEND tracks the two independent handshakes, WAIT_B takes the response
    always_comb begin
        state_d   = state;
        aw_done_d = aw_done;
        w_done_d  = w_done;
        load      = 1'b0;
        bus_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load      = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (o_awvalid && i_awready) aw_done_d = 1'b1;
                if (o_wvalid && i_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)  state_d   = WAIT_B;
            end
            WAIT_B: begin
                if (i_bvalid) begin
                    bus_err_d = (i_bresp != 2'b00);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, handshake flags and the registered write payload
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            drop_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_d;
            aw_done   <= aw_done_d;
            w_done    <= w_done_d;
            drop_q    <= accept && !legal;
            bus_err_q <= bus_err_d;
            if (load) begin
                awaddr_q <= head_addr;
                if (head_addr[2]) begin
                    wdata_q <= {32'(head_eiid), 32'h0};
                    wstrb_q <= 8'hF0;
                end else begin
                    wdata_q <= {32'h0, 32'(head_eiid)};
                    wstrb_q <= 8'h0F;
                end
            end
        end
    end

    assign o_awvalid = (state == SEND) && !aw_done;
    assign o_wvalid  = (state == SEND) && !w_done;
    assign o_bready  = (state == WAIT_B);
    assign o_awaddr  = awaddr_q;
    assign o_awid    = AXI_ID;
    assign o_awlen   = 8'd0;
    assign o_awsize  = 3'b010;
    assign o_awburst = 2'b01;
    assign o_wdata   = wdata_q;
    assign o_wstrb   = wstrb_q;
    assign o_wlast   = o_wvalid;
    assign o_drop    = drop_q;
    assign o_bus_err = bus_err_q;
    assign o_busy    = !empty || (state != IDLE);

endmodule

// File: tb/tb_aplic_msi_tx.sv
// tb/tb_aplic_msi_tx.sv - scoreboard bench for aplic_msi_tx
module tb_aplic_msi_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_level;
    logic [1:0]  req_hart;
    logic [5:0]  req_eiid;
    logic        v1, rdy1;
    logic [0:0]  g1;
    logic        v2, rdy2;
    logic [1:0]  g2;

    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [63:0] awaddr, wdata;
    logic [3:0]  awid;
    logic [7:0]  awlen, wstrb;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic        drop, bus_err, busy;

    logic        awvalid2, wvalid2, wlast2, bvalid2, bready2;
    logic [63:0] awaddr2, wdata2;
    logic [3:0]  awid2;
    logic [7:0]  awlen2, wstrb2;
    logic [2:0]  awsize2;
    logic [1:0]  awburst2;
    logic        drop2, bus_err2, busy2;

    aplic_msi_tx dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(v1), .o_req_ready(rdy1), .i_req_level(req_level),
        .i_req_hart(req_hart), .i_req_guest(g1), .i_req_eiid(req_eiid),
        .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr), .o_awid(awid),
        .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
        .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast),
        .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp),
        .o_drop(drop), .o_bus_err(bus_err), .o_busy(busy)
    );

    aplic_msi_tx #(
        .NR_IMSICS(3), .NR_VS_FILES_PER_IMSIC(2), .NR_SRC_IMSIC(48),
        .M_BASE(64'h3000_0004)
    ) dut2 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(v2), .o_req_ready(rdy2), .i_req_level(req_level),
        .i_req_hart(req_hart), .i_req_guest(g2), .i_req_eiid(req_eiid),
        .o_awvalid(awvalid2), .i_awready(1'b1), .o_awaddr(awaddr2), .o_awid(awid2),
        .o_awlen(awlen2), .o_awsize(awsize2), .o_awburst(awburst2),
        .o_wvalid(wvalid2), .i_wready(1'b1), .o_wdata(wdata2), .o_wstrb(wstrb2), .o_wlast(wlast2),
        .i_bvalid(bvalid2), .o_bready(bready2), .i_bresp(2'b00),
        .o_drop(drop2), .o_bus_err(bus_err2), .o_busy(busy2)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] aw_q[$];
    logic [71:0] w_q[$];
    bit          drop_q[$];
    logic [63:0] aw2_q[$];
    logic [71:0] w2_q[$];
    bit          drop2_q[$];
    logic [1:0]  bresp_q[$];
    int          berr_exp = 0;
    int          aw_hs = 0, w_hs = 0, b_hs = 0;
    bit          b_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // B responders: answer one cycle after bready rises
    always @(posedge clk) begin
        #1;
        bvalid  = b_en && bready;
        bresp   = (bresp_q.size() != 0) ? bresp_q[0] : 2'b00;
        bvalid2 = bready2;
    end

    // Monitor for the main instance
    always @(negedge clk) begin
        if (!rst) begin
            if (awvalid) begin
                checks++;
                if (aw_hs > b_hs) begin
                    errors++;
                    $display("FAIL awvalid_after_hs actual=1 expected=0");
                end
            end
            if (wvalid) begin
                checks++;
                if (w_hs > b_hs) begin
                    errors++;
                    $display("FAIL wvalid_after_hs actual=1 expected=0");
                end
            end
            if (awvalid && awready) begin
                aw_hs++;
                if (aw_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL aw_unexpected actual=%h expected=none", awaddr);
                end else begin
                    chk("awaddr", awaddr, aw_q.pop_front());
                    chk("awid", {60'h0, awid}, 64'h0);
                end
            end
            if (wvalid && wready) begin
                w_hs++;
                if (w_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w_unexpected actual=%h expected=none", wdata);
                end else begin
                    logic [71:0] e;
                    e = w_q.pop_front();
                    chk("wdata", wdata, e[71:8]);
                    chk("wstrb", {56'h0, wstrb}, {56'h0, e[7:0]});
                    chk("wlast", {63'h0, wlast}, 64'h1);
                end
            end
            if (bvalid && bready) begin
                b_hs++;
                if (bresp_q.size() != 0) void'(bresp_q.pop_front());
            end
            if (drop) begin
                checks++;
                if (drop_q.size() == 0) begin
                    errors++;
                    $display("FAIL drop_unexpected actual=1 expected=0");
                end else void'(drop_q.pop_front());
            end
            if (bus_err) begin
                checks++;
                if (berr_exp == 0) begin
                    errors++;
                    $display("FAIL bus_err_unexpected actual=1 expected=0");
                end else berr_exp--;
            end
        end
    end

    // Monitor for the second, non-power-of-two parameterised instance
    always @(negedge clk) begin
        if (!rst) begin
            if (awvalid2) begin
                if (aw2_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL aw2_unexpected actual=%h expected=none", awaddr2);
                end else chk("awaddr2", awaddr2, aw2_q.pop_front());
            end
            if (wvalid2) begin
                if (w2_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w2_unexpected actual=%h expected=none", wdata2);
                end else begin
                    logic [71:0] e;
                    e = w2_q.pop_front();
                    chk("wdata2", wdata2, e[71:8]);
                    chk("wstrb2", {56'h0, wstrb2}, {56'h0, e[7:0]});
                end
            end
            if (drop2) begin
                checks++;
                if (drop2_q.size() == 0) begin
                    errors++;
                    $display("FAIL drop2_unexpected actual=1 expected=0");
                end else void'(drop2_q.pop_front());
            end
        end
    end

    task automatic send(input bit sel, input logic lvl, input logic [1:0] hart,
                        input logic [1:0] guest, input logic [5:0] eiid, input bit is_drop,
                        input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
        int n;
        if (sel == 1'b0) begin
            if (is_drop) drop_q.push_back(1'b1);
            else begin aw_q.push_back(addr); w_q.push_back({data, strb}); end
        end else begin
            if (is_drop) drop2_q.push_back(1'b1);
            else begin aw2_q.push_back(addr); w2_q.push_back({data, strb}); end
        end
        @(negedge clk);
        req_level = lvl; req_hart = hart; req_eiid = eiid;
        g1 = guest[0]; g2 = guest;
        if (sel == 1'b0) v1 = 1'b1; else v2 = 1'b1;
        n = 0;
        while (!(sel ? rdy2 : rdy1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout actual=0 expected=1");
        end
        @(posedge clk);
        #1;
        v1 = 1'b0; v2 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || busy2) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_idle_timeout actual=busy expected=idle", name);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        v1 = 0; v2 = 0; req_level = 0; req_hart = 0; req_eiid = 0; g1 = 0; g2 = 0;
        awready = 1; wready = 1;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", {63'h0, awvalid}, 64'h0);
        chk("rst_wvalid", {63'h0, wvalid}, 64'h0);
        chk("rst_bready", {63'h0, bready}, 64'h0);
        chk("rst_drop", {63'h0, drop}, 64'h0);
        chk("rst_bus_err", {63'h0, bus_err}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_req_ready", {63'h0, rdy1}, 64'h1);
        chk("awsize", {61'h0, awsize}, 64'h2);
        chk("awlen", {56'h0, awlen}, 64'h0);
        chk("awburst", {62'h0, awburst}, 64'h1);
        rst = 0;

        // single M-level write and its enqueue-to-awvalid latency
        send(0, 0, 2'd2, 2'd0, 6'd5, 0, 64'h2400_2000, 64'h5, 8'h0F);
        @(negedge clk);
        chk("lat_cycle1_awvalid", {63'h0, awvalid}, 64'h0);
        chk("lat_busy", {63'h0, busy}, 64'h1);
        @(negedge clk);
        chk("lat_cycle2_awvalid", {63'h0, awvalid}, 64'h1);
        wait_idle("t1");
        chk("t1_busy", {63'h0, busy}, 64'h0);
        chk("t1_aw_drained", 64'(aw_q.size()), 64'h0);

        // S/VS file, and an M request whose guest must be ignored
        send(0, 1, 2'd1, 2'd1, 6'd63, 0, 64'h2800_3000, 64'h3F, 8'h0F);
        send(0, 0, 2'd1, 2'd1, 6'd7,  0, 64'h2400_1000, 64'h7,  8'h0F);
        wait_idle("t2");
        chk("t2_aw_drained", 64'(aw_q.size()), 64'h0);

        // illegal requests on both instances, legal ones on the odd-sized instance
        send(0, 0, 2'd0, 2'd0, 6'd0,  1, 64'h0, 64'h0, 8'h0);
        send(1, 1, 2'd1, 2'd1, 6'd0,  1, 64'h0, 64'h0, 8'h0);
        send(1, 0, 2'd3, 2'd0, 6'd1,  1, 64'h0, 64'h0, 8'h0);
        send(1, 0, 2'd0, 2'd0, 6'd48, 1, 64'h0, 64'h0, 8'h0);
        send(1, 1, 2'd0, 2'd3, 6'd1,  1, 64'h0, 64'h0, 8'h0);
        send(1, 1, 2'd2, 2'd2, 6'd47, 0, 64'h2800_8000, 64'h2F, 8'h0F);
        send(1, 0, 2'd1, 2'd3, 6'd9,  0, 64'h3000_1004, 64'h0000_0009_0000_0000, 8'hF0);
        wait_idle("t3");
        chk("t3_drop_drained", 64'(drop_q.size()), 64'h0);
        chk("t3_drop2_drained", 64'(drop2_q.size()), 64'h0);
        chk("t3_aw2_drained", 64'(aw2_q.size()), 64'h0);

        // back-pressure: one in flight plus four queued fills the FIFO
        awready = 0;
        send(0, 0, 2'd0, 2'd0, 6'd1,  0, 64'h2400_0000, 64'h1,  8'h0F);
        send(0, 0, 2'd3, 2'd0, 6'd2,  0, 64'h2400_3000, 64'h2,  8'h0F);
        send(0, 1, 2'd0, 2'd0, 6'd3,  0, 64'h2800_0000, 64'h3,  8'h0F);
        send(0, 1, 2'd3, 2'd1, 6'd4,  0, 64'h2800_7000, 64'h4,  8'h0F);
        send(0, 1, 2'd2, 2'd0, 6'd62, 0, 64'h2800_4000, 64'h3E, 8'h0F);
        @(negedge clk);
        chk("full_req_ready", {63'h0, rdy1}, 64'h0);
        chk("full_busy", {63'h0, busy}, 64'h1);
        repeat (3) @(negedge clk);
        awready = 1;
        wait_idle("t4");
        chk("t4_aw_drained", 64'(aw_q.size()), 64'h0);
        chk("t4_w_drained", 64'(w_q.size()), 64'h0);

        // SLVERR on the first write, the second still goes out
        bresp_q.push_back(2'b10);
        berr_exp = 1;
        send(0, 0, 2'd1, 2'd0, 6'd20, 0, 64'h2400_1000, 64'h14, 8'h0F);
        send(0, 1, 2'd2, 2'd1, 6'd21, 0, 64'h2800_5000, 64'h15, 8'h0F);
        wait_idle("t5");
        chk("t5_bus_err_seen", 64'(berr_exp), 64'h0);
        chk("t5_aw_drained", 64'(aw_q.size()), 64'h0);

        // reset while waiting for B abandons the write and the queued request
        b_en = 0;
        send(0, 0, 2'd3, 2'd0, 6'd10, 0, 64'h2400_3000, 64'hA, 8'h0F);
        send(0, 0, 2'd0, 2'd0, 6'd11, 0, 64'h2400_0000, 64'hB, 8'h0F);
        n = 0;
        while (!bready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_wait_b", {63'h0, bready}, 64'h1);
        #2;
        rst = 1;
        #1;
        chk("t6_rst_awvalid", {63'h0, awvalid}, 64'h0);
        chk("t6_rst_wvalid", {63'h0, wvalid}, 64'h0);
        chk("t6_rst_bready", {63'h0, bready}, 64'h0);
        chk("t6_rst_busy", {63'h0, busy}, 64'h0);
        chk("t6_rst_req_ready", {63'h0, rdy1}, 64'h1);
        aw_q.delete();
        w_q.delete();
        b_hs = aw_hs;
        w_hs = aw_hs;
        @(negedge clk);
        rst = 0;
        b_en = 1;
        repeat (20) @(negedge clk);
        chk("t6_after_busy", {63'h0, busy}, 64'h0);
        chk("t6_after_awvalid", {63'h0, awvalid}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
